// File: rtl/multitap_delay.sv
// multitap_delay: multi-tap echo with feedback and dry/wet blend.
// TAPS read taps share one circular sample buffer of 2**DLY_B entries. Tap 0
// feeds a scaled copy of itself back into the buffer. The wet signal is the
// average of all taps, and it is blended with the dry input.
// Optional feature: define MULTITAP_DELAY_SAT_EN to saturate wr_data and out
// to the signed SIG_BITS range. Without it, both wrap (two's complement truncate).
//
// Handshake: a sample is taken on a rising clk edge where in_valid=1 and
// in_ready=1. in_ready is high only in IDLE. Strobes seen while in_ready=0 are
// dropped, not queued. out_valid pulses for one cycle when out is updated,
// TAPS+2 cycles after the accept edge, and out holds between updates.
module multitap_delay #(
    parameter int SIG_BITS = 16,
    parameter int DLY_B    = 14,
    parameter int TAPS     = 2,
    parameter int BLEND_B  = 10,
    parameter int FDB_B    = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic [SIG_BITS-1:0]     in,
    output logic                    in_ready,
    output logic [SIG_BITS-1:0]     out,
    output logic                    out_valid,
    input  logic [BLEND_B-1:0]      blend,
    input  logic [TAPS*DLY_B-1:0]   delay,
    input  logic [FDB_B-1:0]        feedbk
);

    localparam int DEPTH = 1 << DLY_B;
    localparam int CW    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int SH    = $clog2(TAPS);
    localparam int ACW   = SIG_BITS + 3;
    localparam int CTL_B = (BLEND_B > FDB_B) ? BLEND_B : FDB_B;
    localparam int W     = ACW + CTL_B + 4;
    localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        IDLE  = 3'd1,
        READ  = 3'd2,
        MIX   = 3'd3,
        WRITE = 3'd4
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [DLY_B-1:0]          wr_ptr;
    logic [CW-1:0]             tap_cnt;
    logic signed [SIG_BITS-1:0] in_q;
    logic [BLEND_B-1:0]        blend_q;
    logic [TAPS*DLY_B-1:0]     delay_q;
    logic [FDB_B-1:0]          feedbk_q;
    logic                      rd_vld;
    logic [CW-1:0]             rd_idx;
    logic signed [ACW-1:0]     acc;
    logic signed [SIG_BITS-1:0] tap0_q;
    logic signed [SIG_BITS-1:0] rd_data;
    logic [DLY_B-1:0]          rd_addr;
    logic                      mem_we;
    logic [SIG_BITS-1:0]       mem_wd;
    logic [SIG_BITS-1:0]       mem [DEPTH];

    logic signed [ACW-1:0]     wet_sh;
    logic signed [W-1:0]       in_x;
    logic signed [W-1:0]       wet_x;
    logic signed [W-1:0]       tap0_x;
    logic signed [W-1:0]       w_wet;
    logic signed [W-1:0]       w_dry;
    logic signed [W-1:0]       w_fb;
    logic signed [W-1:0]       mix;
    logic signed [W-1:0]       out_full;
    logic signed [W-1:0]       fb;
    logic signed [W-1:0]       wr_full;
    logic [SIG_BITS-1:0]       wr_data;
    logic [SIG_BITS-1:0]       out_next;

    // Narrow a wide signed result to SIG_BITS: clamp or wrap.
`ifdef MULTITAP_DELAY_SAT_EN
    localparam logic signed [W-1:0] SMAX = {{(W-SIG_BITS+1){1'b0}}, {(SIG_BITS-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {{(W-SIG_BITS+1){1'b1}}, {(SIG_BITS-1){1'b0}}};

    function automatic logic [SIG_BITS-1:0] fit(input logic signed [W-1:0] v);
        if (v > SMAX) begin
            return SMAX[SIG_BITS-1:0];
        end else if (v < SMIN) begin
            return SMIN[SIG_BITS-1:0];
        end
        return v[SIG_BITS-1:0];
    endfunction
`else
    function automatic logic [SIG_BITS-1:0] fit(input logic signed [W-1:0] v);
        return v[SIG_BITS-1:0];
    endfunction
`endif

    assign in_ready = (state_q == IDLE);

    // State register; reset restarts the buffer clear from any state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (wr_ptr == {DLY_B{1'b1}}) state_d = IDLE;
            IDLE:    if (in_valid) state_d = READ;
            READ:    if (tap_cnt == LAST_TAP) state_d = MIX;
            MIX:     state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    // Tap read address. A delay of 0 lands on the slot about to be
    // overwritten, which holds the oldest sample.
    always_comb begin
        rd_addr = wr_ptr - delay_q[int'(tap_cnt)*DLY_B +: DLY_B];
    end

    // Blend and feedback arithmetic, all full width before the shifts.
    always_comb begin
        wet_sh   = acc >>> SH;
        in_x     = {{(W-SIG_BITS){in_q[SIG_BITS-1]}}, in_q};
        wet_x    = {{(W-ACW){wet_sh[ACW-1]}}, wet_sh};
        tap0_x   = {{(W-SIG_BITS){tap0_q[SIG_BITS-1]}}, tap0_q};
        w_wet    = {{(W-BLEND_B){1'b0}}, blend_q};
        w_dry    = (W'(1) << BLEND_B) - w_wet;
        w_fb     = {{(W-FDB_B){1'b0}}, feedbk_q};
        mix      = in_x * w_dry + wet_x * w_wet;
        out_full = mix >>> BLEND_B;
        fb       = (tap0_x * w_fb) >>> FDB_B;
        wr_full  = in_x + fb;
        wr_data  = fit(wr_full);
        out_next = fit(out_full);
    end

    // Buffer write source: zeros while clearing, mixed sample otherwise.
    always_comb begin
        mem_we = (state_q == CLEAR) || (state_q == WRITE);
        mem_wd = (state_q == CLEAR) ? '0 : wr_data;
    end

    // Sample buffer: one write port, one synchronous read port, no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= mem_wd;
        end
        rd_data <= mem[rd_addr];
    end

    // Control capture, tap accumulation, pointer and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            tap_cnt   <= '0;
            in_q      <= '0;
            blend_q   <= '0;
            delay_q   <= '0;
            feedbk_q  <= '0;
            rd_vld    <= 1'b0;
            rd_idx    <= '0;
            acc       <= '0;
            tap0_q    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            rd_vld    <= 1'b0;
            // Read data arrives one cycle after its address; add it in here.
            if (rd_vld) begin
                acc <= acc + {{(ACW-SIG_BITS){rd_data[SIG_BITS-1]}}, rd_data};
                if (rd_idx == '0) begin
                    tap0_q <= rd_data;
                end
            end
            case (state_q)
                CLEAR: begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                IDLE: begin
                    if (in_valid) begin
                        in_q     <= in;
                        blend_q  <= blend;
                        delay_q  <= delay;
                        feedbk_q <= feedbk;
                        tap_cnt  <= '0;
                        acc      <= '0;
                    end
                end
                READ: begin
                    rd_vld  <= 1'b1;
                    rd_idx  <= tap_cnt;
                    tap_cnt <= tap_cnt + 1'b1;
                end
                WRITE: begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    out       <= out_next;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
